// File: rtl/security_alarm_ctrl.sv
// Multi-channel debounced alarm controller: arm/entry/alarm FSM with latched per-channel alarms.
// Optional pulsed siren drive is enabled by defining SIREN_PULSE_EN; otherwise siren follows alarm.
module security_alarm_ctrl #(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       DEB_CYCLES  = 4,
    parameter int unsigned       ENTRY_DELAY = 16,
    parameter logic [NUM_CH-1:0] DELAY_MASK  = 4'b0010,
    parameter logic [NUM_CH-1:0] FIRE_MASK   = 4'b0001,
    parameter int unsigned       SIREN_HALF  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              ack,
    input  logic [NUM_CH-1:0] sensor,
    output logic [NUM_CH-1:0] ch_state,
    output logic [NUM_CH-1:0] alarm_latch,
    output logic              alarm,
    output logic [1:0]        fsm_state,
    output logic              siren
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned EW = $clog2(ENTRY_DELAY + 1);

    if (NUM_CH < 1 || NUM_CH > 16 || DEB_CYCLES < 1 || ENTRY_DELAY < 1 || SIREN_HALF < 1)
    begin : g_bad_param
        $error("security_alarm_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_ENTRY    = 2'b10,
        ST_ALARM    = 2'b11
    } state_t;

    state_t              state;
    logic [DW-1:0]       deb_cnt [NUM_CH];
    logic [NUM_CH-1:0]   ch_prev;
    logic [NUM_CH-1:0]   pending;
    logic [EW-1:0]       entry_cnt;

    logic [NUM_CH-1:0]   trip;
    logic [NUM_CH-1:0]   d_trip;
    logic                expire;
    logic [NUM_CH-1:0]   set_c;
    logic [NUM_CH-1:0]   clr_c;
    logic [NUM_CH-1:0]   latch_nxt;
    logic [NUM_CH-1:0]   pending_nxt;
    logic [EW-1:0]       entry_cnt_nxt;
    logic                alarm_nxt;

    assign fsm_state = state;

    // Per-channel debounce: flip after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_state <= '0;
            ch_prev  <= '0;
            for (int i = 0; i < NUM_CH; i++) deb_cnt[i] <= '0;
        end else begin
            ch_prev <= ch_state;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sensor[i] != ch_state[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        ch_state[i] <= sensor[i];
                        deb_cnt[i]  <= '0;
                    end else begin
                        deb_cnt[i]  <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Latch set/clear and entry-delay bookkeeping; sets always win over clears
    always_comb begin
        trip          = ch_state & ~ch_prev;
        d_trip        = trip & DELAY_MASK & ~FIRE_MASK;
        expire        = (pending != '0) && arm && (entry_cnt <= EW'(1));
        set_c         = (trip & FIRE_MASK)
                      | (arm ? (trip & ~DELAY_MASK) : '0)
                      | (expire ? (pending | d_trip) : '0);
        clr_c         = '0;
        pending_nxt   = '0;
        entry_cnt_nxt = '0;
        if (state == ST_ALARM) begin
            if (!arm) clr_c = clr_c | ~FIRE_MASK;
            if (ack)  clr_c = clr_c | ~ch_state;
        end
        latch_nxt = (alarm_latch & ~clr_c) | set_c;
        alarm_nxt = |latch_nxt;
        if (arm) begin
            if (pending != '0) begin
                if (!expire) begin
                    pending_nxt   = pending | d_trip;
                    entry_cnt_nxt = entry_cnt - EW'(1);
                end
            end else if (state == ST_ARMED && d_trip != '0) begin
                pending_nxt   = d_trip;
                entry_cnt_nxt = EW'(ENTRY_DELAY);
            end
        end
    end

    // Arm/entry/alarm state machine with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_DISARMED;
            alarm_latch <= '0;
            alarm       <= 1'b0;
            pending     <= '0;
            entry_cnt   <= '0;
        end else begin
            alarm_latch <= latch_nxt;
            alarm       <= alarm_nxt;
            pending     <= pending_nxt;
            entry_cnt   <= entry_cnt_nxt;
            if (set_c != '0) begin
                state <= ST_ALARM;
            end else begin
                unique case (state)
                    ST_DISARMED: if (arm) state <= ST_ARMED;
                    ST_ARMED: begin
                        if (!arm && alarm_latch == '0) state <= ST_DISARMED;
                        else if (pending_nxt != '0)    state <= ST_ENTRY;
                    end
                    ST_ENTRY: if (!arm) state <= ST_DISARMED;
                    ST_ALARM: begin
                        if (latch_nxt == '0) begin
                            if (pending_nxt != '0) state <= ST_ENTRY;
                            else if (arm)          state <= ST_ARMED;
                            else                   state <= ST_DISARMED;
                        end
                    end
                    default: state <= ST_DISARMED;
                endcase
            end
        end
    end

`ifdef SIREN_PULSE_EN
    localparam int unsigned SW = $clog2(SIREN_HALF + 1);
    logic [SW-1:0] siren_cnt;

    // Square-wave siren, high on the edge alarm rises
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            siren     <= 1'b0;
            siren_cnt <= '0;
        end else if (!alarm_nxt) begin
            siren     <= 1'b0;
            siren_cnt <= '0;
        end else if (!alarm) begin
            siren     <= 1'b1;
            siren_cnt <= '0;
        end else if (siren_cnt == SW'(SIREN_HALF - 1)) begin
            siren     <= ~siren;
            siren_cnt <= '0;
        end else begin
            siren_cnt <= siren_cnt + SW'(1);
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) siren <= 1'b0;
        else       siren <= alarm_nxt;
    end
`endif

endmodule

// File: tb/tb_security_alarm_ctrl.sv
// Directed bench for security_alarm_ctrl at default parameters; inputs change and outputs
// are sampled on the falling clock edge.
module tb_security_alarm_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       arm;
    logic       ack;
    logic [3:0] sensor;
    logic [3:0] ch_state;
    logic [3:0] alarm_latch;
    logic       alarm;
    logic [1:0] fsm_state;
    logic       siren;

    int n_tests = 0;
    int n_fail  = 0;

    security_alarm_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .ack         (ack),
        .sensor      (sensor),
        .ch_state    (ch_state),
        .alarm_latch (alarm_latch),
        .alarm       (alarm),
        .fsm_state   (fsm_state),
        .siren       (siren)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; ack = 1'b0; sensor = 4'b0000;
        step(2);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'd0);
        check("rst_latch", 32'(alarm_latch), 32'd0);
        check("rst_ch", 32'(ch_state), 32'd0);
        check("rst_siren", 32'(siren), 32'd0);
        reset = 1'b0;

        // glitch filter
        arm = 1'b1;
        step(1);
        check("t1_armed", 32'(fsm_state), 32'd1);
        sensor = 4'b0100;
        step(3);
        sensor = 4'b0000;
        step(6);
        check("t1_ch", 32'(ch_state), 32'd0);
        check("t1_alarm", 32'(alarm), 32'd0);

        // armed trip, ack while high, ack after release
        sensor = 4'b0100;
        step(4);
        check("t2_ch_e4", 32'(ch_state), 32'b0100);
        check("t2_alarm_e4", 32'(alarm), 32'd0);
        step(1);
        check("t2_alarm_e5", 32'(alarm), 32'd1);
        check("t2_fsm_e5", 32'(fsm_state), 32'd3);
        check("t2_latch", 32'(alarm_latch), 32'b0100);
        check("t2_siren", 32'(siren), 32'd1);
        pulse_ack();
        check("t2_ack_high", 32'(alarm_latch), 32'b0100);
        sensor = 4'b0000;
        step(4);
        check("t2_ch_low", 32'(ch_state), 32'd0);
        pulse_ack();
        check("t2_cleared", 32'(alarm), 32'd0);
        check("t2_fsm_armed", 32'(fsm_state), 32'd1);

        // ack and new trip on the same edge
        sensor = 4'b1000;
        step(5);
        check("b1_latch3", 32'(alarm_latch), 32'b1000);
        sensor = 4'b0000;
        step(4);
        sensor = 4'b0100;
        step(4);
        pulse_ack();
        check("b1_trip_wins", 32'(alarm_latch), 32'b0100);
        check("b1_fsm", 32'(fsm_state), 32'd3);
        sensor = 4'b0000;
        step(4);
        pulse_ack();
        check("b1_fsm_armed", 32'(fsm_state), 32'd1);

        // entry delay, disarmed in time
        sensor = 4'b0010;
        step(4);
        check("t3_ch", 32'(ch_state), 32'b0010);
        check("t3_fsm_pre", 32'(fsm_state), 32'd1);
        step(1);
        check("t3_entry", 32'(fsm_state), 32'd2);
        step(8);
        check("t3_still_entry", 32'(fsm_state), 32'd2);
        arm = 1'b0;
        step(1);
        check("t3_disarmed", 32'(fsm_state), 32'd0);
        sensor = 4'b0000;
        step(20);
        check("t3_no_alarm", 32'(alarm), 32'd0);
        check("t3_fsm_end", 32'(fsm_state), 32'd0);

        // entry delay expiry: alarm exactly 17 edges after ch_state rises
        arm = 1'b1;
        step(1);
        check("t4_armed", 32'(fsm_state), 32'd1);
        sensor = 4'b0010;
        step(4);
        check("t4_ch", 32'(ch_state), 32'b0010);
        step(16);
        check("t4_alarm_e16", 32'(alarm), 32'd0);
        check("t4_fsm_e16", 32'(fsm_state), 32'd2);
        step(1);
        check("t4_alarm_e17", 32'(alarm), 32'd1);
        check("t4_fsm_e17", 32'(fsm_state), 32'd3);
        check("t4_latch", 32'(alarm_latch), 32'b0010);
        sensor = 4'b0000;
        step(4);
        pulse_ack();
        check("t4_cleared", 32'(fsm_state), 32'd1);

        // fire while disarmed
        arm = 1'b0;
        step(1);
        check("t5_disarmed", 32'(fsm_state), 32'd0);
        sensor = 4'b0001;
        step(4);
        check("t5_alarm_e4", 32'(alarm), 32'd0);
        step(1);
        check("t5_alarm_e5", 32'(alarm), 32'd1);
        check("t5_latch", 32'(alarm_latch), 32'b0001);
        arm = 1'b1;
        step(2);
        arm = 1'b0;
        step(2);
        check("t5_arm_toggle", 32'(alarm_latch), 32'b0001);
        pulse_ack();
        check("t5_ack_high", 32'(alarm_latch), 32'b0001);
        sensor = 4'b0000;
        step(4);
        pulse_ack();
        check("t5_cleared", 32'(alarm), 32'd0);
        check("t5_fsm", 32'(fsm_state), 32'd0);

        // reset during alarm
        arm = 1'b1;
        step(1);
        sensor = 4'b0100;
        step(5);
        check("t6_alarm", 32'(alarm), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_alarm", 32'(alarm), 32'd0);
        check("t6_rst_fsm", 32'(fsm_state), 32'd0);
        check("t6_rst_latch", 32'(alarm_latch), 32'd0);
        check("t6_rst_ch", 32'(ch_state), 32'd0);
        check("t6_rst_siren", 32'(siren), 32'd0);
        step(1);
        reset = 1'b0;
        step(4);
        check("t6_ch_restart", 32'(ch_state), 32'b0100);
        check("t6_alarm_e4", 32'(alarm), 32'd0);
        step(1);
        check("t6_alarm_e5", 32'(alarm), 32'd1);
        check("t6_siren_rise", 32'(siren), 32'd1);
`ifdef SIREN_PULSE_EN
        step(7);
        check("t6_siren_hi", 32'(siren), 32'd1);
        step(1);
        check("t6_siren_lo", 32'(siren), 32'd0);
        step(8);
        check("t6_siren_hi2", 32'(siren), 32'd1);
`else
        step(8);
        check("t6_siren_steady", 32'(siren), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
